mem_bus_arbiter: RTL

- Shares the single 12-bit address / 4-bit data memory bus between two masters: m0 (the CPU core) and m1 (a program loader / DMA engine).
- Sits between the masters and the memory/IO decode. Grants one owner at a time.
- Enforces a one-cycle turnaround when ownership changes and caps burst length so neither master starves.

---
 rtl/mem_bus_arbiter_if.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the memory/IO decode.
// The slave modport is the arbiter's view; the master modport is the masters' and memory side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_we;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_we;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        owner;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_we,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    output mem_addr, mem_wdata, mem_we, owner
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_we,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    input  mem_addr, mem_wdata, mem_we, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter with one-cycle turnaround and a burst cap.
// Define ARB_ROUND_ROBIN_EN to break IDLE ties against the last owner; otherwise m0 wins ties.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 8
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10,
    TURN = 2'b11
  } state_t;

  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = (MAX_BURST == 0) ? {CNT_W{1'b0}} : CNT_W'(MAX_BURST - 1);
  localparam logic CAP_EN = (MAX_BURST != 0);

  state_t            state_r;
  state_t            state_next_s;
  logic [CNT_W-1:0]  burst_cnt_r;
  logic              last_owner_r;   // 1'b0 = m0, 1'b1 = m1
  logic              m0_rvalid_r;
  logic              m1_rvalid_r;
  logic              cap_hit_s;
  logic              tie_pick_m1_s;

  // IDLE tie-break selection and burst-cap detection
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    tie_pick_m1_s = ~last_owner_r;
`else
    tie_pick_m1_s = 1'b0;
`endif
    cap_hit_s = CAP_EN && (burst_cnt_r == CNT_LAST);
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          state_next_s = tie_pick_m1_s ? OWN1 : OWN0;
        end else if (bus.m0_req) begin
          state_next_s = OWN0;
        end else if (bus.m1_req) begin
          state_next_s = OWN1;
        end else begin
          state_next_s = IDLE;
        end
      end
      OWN0: begin
        if (!bus.m0_req) begin
          state_next_s = bus.m1_req ? TURN : IDLE;
        end else if (bus.m1_req && cap_hit_s) begin
          state_next_s = TURN;
        end else begin
          state_next_s = OWN0;
        end
      end
      OWN1: begin
        if (!bus.m1_req) begin
          state_next_s = bus.m0_req ? TURN : IDLE;
        end else if (bus.m0_req && cap_hit_s) begin
          state_next_s = TURN;
        end else begin
          state_next_s = OWN1;
        end
      end
      TURN: begin
        // Hand over to the master that did not just own the bus, if it still wants it
        if (last_owner_r) begin
          if (bus.m0_req) begin
            state_next_s = OWN0;
          end else if (bus.m1_req) begin
            state_next_s = OWN1;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          if (bus.m1_req) begin
            state_next_s = OWN1;
          end else if (bus.m0_req) begin
            state_next_s = OWN0;
          end else begin
            state_next_s = IDLE;
          end
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Bus mux and grant decode from the state register
  always_comb begin
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.mem_we    = 1'b0;
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.owner     = 2'b00;
    case (state_r)
      OWN0: begin
        bus.mem_addr  = bus.m0_addr;
        bus.mem_wdata = bus.m0_wdata;
        bus.mem_we    = bus.m0_we & bus.m0_req;
        bus.m0_gnt    = 1'b1;
        bus.owner     = 2'b01;
      end
      OWN1: begin
        bus.mem_addr  = bus.m1_addr;
        bus.mem_wdata = bus.m1_wdata;
        bus.mem_we    = bus.m1_we & bus.m1_req;
        bus.m1_gnt    = 1'b1;
        bus.owner     = 2'b10;
      end
      IDLE:    bus.owner = 2'b00;
      TURN:    bus.owner = 2'b00;
      default: bus.owner = 2'b00;
    endcase
    bus.m0_rvalid = m0_rvalid_r;
    bus.m1_rvalid = m1_rvalid_r;
  end

  // State, burst counter and last-owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      burst_cnt_r  <= {CNT_W{1'b0}};
      last_owner_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if ((state_next_s == OWN0) && (state_r != OWN0)) begin
        burst_cnt_r  <= {CNT_W{1'b0}};
        last_owner_r <= 1'b0;
      end else if ((state_next_s == OWN1) && (state_r != OWN1)) begin
        burst_cnt_r  <= {CNT_W{1'b0}};
        last_owner_r <= 1'b1;
      end else if (((state_r == OWN0) && bus.m0_req) || ((state_r == OWN1) && bus.m1_req)) begin
        if (burst_cnt_r != CNT_SAT) begin
          burst_cnt_r <= burst_cnt_r + CNT_W'(1);
        end else begin
          burst_cnt_r <= burst_cnt_r;
        end
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end
  end

  // Read-data valid: memory answers one cycle after an owned read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
    end else begin
      m0_rvalid_r <= (state_r == OWN0) && bus.m0_req && !bus.m0_we;
      m1_rvalid_r <= (state_r == OWN1) && bus.m1_req && !bus.m1_we;
    end
  end

endmodule
